bpsk_pb_controller: RTL and testbench

BPSK_PB_CONTROLLER -- requirements
Module: bpsk_pb_controller

---
 rtl/bpsk_pb_controller_pkg.sv | 26 ++
 rtl/bpsk_pb_controller_prbs7_gen.sv | 32 +++
 rtl/bpsk_pb_controller.sv | 114 +++++++++++
 tb/tb_bpsk_pb_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pb_controller_pkg.sv
// Shared encodings for the push-button BPSK test-pattern controller and the modulator.
// Holds the mode codes, the PRBS7 taps and the default LFSR seed.
package bpsk_pb_controller_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_ALT   = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  // x^7 + x^6 + 1: feedback taken from bits 6 and 5 of a shift-left register
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 5;
  localparam logic [6:0]  PRBS7_SEED_DEFAULT = 7'h7F;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_IDLE:  return MODE_ALT;
      MODE_ALT:   return MODE_PRBS;
      MODE_PRBS:  return MODE_CONST;
      default:    return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bpsk_pb_controller_prbs7_gen.sv
// PRBS7 Fibonacci LFSR; bit_out is the MSB, presented before the step shifts it out.
// A non-zero seed keeps the register off the all-zero lock-up state.
module prbs7_gen
  import bpsk_pb_controller_pkg::*;
#(
  parameter logic [6:0] SEED = PRBS7_SEED_DEFAULT
) (
  input  logic Myclk,
  input  logic rst,
  input  logic load,
  input  logic step,
  output logic bit_out
);

  logic [6:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)
      lfsr_d = SEED;
    else if (step)
      lfsr_d = {lfsr_q[5:0], lfsr_q[PRBS7_TAP_A] ^ lfsr_q[PRBS7_TAP_B]};
  end

  always_ff @(posedge Myclk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign bit_out = lfsr_q[6];

endmodule

// File: rtl/bpsk_pb_controller.sv
// Push-button mode controller: each press steps IDLE->ALT->PRBS->CONST->IDLE and the
// selected pattern is serialised one bit every BIT_DIV clocks with a one-cycle strobe.
module bpsk_pb_controller
  import bpsk_pb_controller_pkg::*;
#(
  parameter int unsigned BIT_DIV   = 5000,
  parameter logic [6:0]  PRBS_SEED = PRBS7_SEED_DEFAULT
) (
  input  logic       Myclk,
  input  logic       rst,
  input  logic       PB_db,
  output logic [1:0] mode,
  output logic       tx_en,
  output logic       data_bit,
  output logic       bit_stb
);

  localparam logic [15:0] TC_CNT = 16'(BIT_DIV - 1);

  mode_e       state_q, state_d;
  logic        pb_q, pb_d;
  logic        armed_q, armed_d;
  logic        tx_en_q, tx_en_d;
  logic [15:0] cnt_q, cnt_d;
  logic        alt_q, alt_d;
  logic        data_bit_q, data_bit_d;
  logic        bit_stb_q, bit_stb_d;
  logic        press;
  logic        lfsr_load, lfsr_step, lfsr_bit;

  prbs7_gen #(.SEED(PRBS_SEED)) u_prbs (
    .Myclk   (Myclk),
    .rst     (rst),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .bit_out (lfsr_bit)
  );

  // armed_q keeps the first post-reset clock from seeing a level held through reset as an edge
  assign press = armed_q & PB_db & ~pb_q;

  always_comb begin
    state_d    = state_q;
    pb_d       = PB_db;
    armed_d    = 1'b1;
    tx_en_d    = tx_en_q;
    cnt_d      = cnt_q;
    alt_d      = alt_q;
    data_bit_d = data_bit_q;
    bit_stb_d  = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    if (press) begin
      // a press wins over a coincident terminal count and restarts the bit timing
      state_d    = next_mode(state_q);
      tx_en_d    = (state_d != MODE_IDLE);
      cnt_d      = '0;
      alt_d      = 1'b0;
      data_bit_d = 1'b0;
      lfsr_load  = 1'b1;
    end else if (state_q == MODE_IDLE) begin
      cnt_d      = '0;
      data_bit_d = 1'b0;
    end else if (cnt_q == TC_CNT) begin
      cnt_d     = '0;
      bit_stb_d = 1'b1;
      case (state_q)
        MODE_ALT: begin
          data_bit_d = ~alt_q;
          alt_d      = ~alt_q;
        end
        MODE_PRBS: begin
          data_bit_d = lfsr_bit;
          lfsr_step  = 1'b1;
        end
        default: data_bit_d = 1'b1;
      endcase
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Myclk or posedge rst) begin
    if (rst) state_q <= MODE_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge Myclk or posedge rst) begin
    if (rst) begin
      pb_q       <= 1'b0;
      armed_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      cnt_q      <= '0;
      alt_q      <= 1'b0;
      data_bit_q <= 1'b0;
      bit_stb_q  <= 1'b0;
    end else begin
      pb_q       <= pb_d;
      armed_q    <= armed_d;
      tx_en_q    <= tx_en_d;
      cnt_q      <= cnt_d;
      alt_q      <= alt_d;
      data_bit_q <= data_bit_d;
      bit_stb_q  <= bit_stb_d;
    end
  end

  assign mode     = state_q;
  assign tx_en    = tx_en_q;
  assign data_bit = data_bit_q;
  assign bit_stb  = bit_stb_q;

endmodule

// File: tb/tb_bpsk_pb_controller.sv
// Directed bench for bpsk_pb_controller at BIT_DIV=4 with a per-cycle reference model
// expressed as "cycles since mode entry" and a closed-form PRBS7 sequence.
module tb_bpsk_pb_controller;

  localparam int BIT_DIV = 4;

  logic       Myclk, rst, PB_db;
  logic [1:0] mode;
  logic       tx_en, data_bit, bit_stb;

  bpsk_pb_controller #(.BIT_DIV(BIT_DIV), .PRBS_SEED(7'h7F)) dut (
    .Myclk    (Myclk),
    .rst      (rst),
    .PB_db    (PB_db),
    .mode     (mode),
    .tx_en    (tx_en),
    .data_bit (data_bit),
    .bit_stb  (bit_stb)
  );

  initial begin
    Myclk = 1'b0;
    forever #5 Myclk = ~Myclk;
  end

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  int prbs_seq [127];
  int stb_cyc [$];
  int stb_bit [$];

  // reference model state
  int m_mode  = 0;
  int m_age   = 0;
  bit m_prev  = 1'b0;
  bit m_armed = 1'b0;

  always @(posedge Myclk) cyc <= cyc + 1;

  always @(posedge Myclk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_age   <= 0;
      m_prev  <= 1'b0;
      m_armed <= 1'b0;
    end else begin
      m_prev  <= PB_db;
      m_armed <= 1'b1;
      if (m_armed && PB_db && !m_prev) begin
        m_mode <= (m_mode + 1) % 4;
        m_age  <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  function automatic int exp_bit(input int md, input int age);
    int k;
    k = age / BIT_DIV;
    if (md == 0 || k == 0) return 0;
    if (md == 1) return k % 2;
    if (md == 2) return prbs_seq[(k - 1) % 127];
    return 1;
  endfunction

  always @(negedge Myclk) begin
    logic [4:0] act, expv;
    logic       e_stb, e_bit;
    e_stb = (m_mode != 0) && (m_age > 0) && (m_age % BIT_DIV == 0);
    e_bit = exp_bit(m_mode, m_age) != 0;
    act   = {mode, tx_en, bit_stb, data_bit};
    expv  = {2'(m_mode), m_mode != 0, e_stb, e_bit};
    if (!rst && bit_stb) begin
      stb_cyc.push_back(cyc);
      stb_bit.push_back(int'(data_bit));
    end
    if (chk_en) begin
      vec_cnt++;
      if (act !== expv) begin
        miss_cnt++;
        $display("FAIL model cyc=%0d {mode,tx_en,stb,bit} got %b expected %b", cyc, act, expv);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    vec_cnt++;
    if (act != expv) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Myclk);
      #2;
    end
  endtask

  initial begin
    int         p, s, exp_modes[4];
    bit         found;
    logic [7:0] exp8;
    logic [6:0] seed;

    seed = 7'h7F;
    for (int i = 0; i < 7; i++) prbs_seq[i] = int'(seed[6-i]);
    for (int i = 7; i < 127; i++) prbs_seq[i] = prbs_seq[i-7] ^ prbs_seq[i-6];
    exp8 = 8'b1111_1110;
    exp_modes = '{1, 2, 3, 0};

    rst = 1'b1;
    PB_db = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_mode", int'(mode), 0);
    chk("rst_out", int'({tx_en, bit_stb, data_bit}), 0);
    rst = 1'b0;
    tick(2);

    // held press enters ALT exactly once; strobes at press+5, then every 4
    stb_cyc.delete(); stb_bit.delete();
    p = cyc;
    PB_db = 1'b1;
    tick(20);
    chk("alt_mode_held", int'(mode), 1);
    chk("alt_tx_en", int'(tx_en), 1);
    PB_db = 1'b0;
    tick(5);
    chk("alt_nstb", int'(stb_cyc.size() >= 4), 1);
    if (stb_cyc.size() >= 4) begin
      chk("alt_first_lat", stb_cyc[0] - p, 5);
      chk("alt_spacing", stb_cyc[1] - stb_cyc[0], 4);
      chk("alt_b0", stb_bit[0], 1);
      chk("alt_b1", stb_bit[1], 0);
      chk("alt_b2", stb_bit[2], 1);
      chk("alt_b3", stb_bit[3], 0);
    end

    // press on the terminal-count cycle: strobe suppressed, timing restarts
    found = 1'b0;
    s = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bit_stb) begin
        found = 1'b1;
        s = cyc;
        break;
      end
    end
    chk("tc_found_stb", int'(found), 1);
    tick(3);
    stb_cyc.delete(); stb_bit.delete();
    PB_db = 1'b1;
    tick(1);
    chk("tc_no_stb", int'(bit_stb), 0);
    chk("tc_mode", int'(mode), 2);
    PB_db = 1'b0;
    tick(6);
    chk("tc_restart_nstb", int'(stb_cyc.size() >= 1), 1);
    if (stb_cyc.size() >= 1) chk("tc_restart_cyc", stb_cyc[0] - s, 8);

    // PRBS7 sequence from seed 7F, and its 127-bit period
    tick(540);
    chk("prbs_nstb", int'(stb_bit.size() >= 135), 1);
    if (stb_bit.size() >= 135) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("prbs_b%0d", i), stb_bit[i], int'(exp8[7-i]));
        chk($sformatf("prbs_b%0d", 127 + i), stb_bit[127+i], int'(exp8[7-i]));
      end
    end

    // asynchronous reset mid-sequence
    rst = 1'b1;
    #1;
    chk("arst_mode", int'(mode), 0);
    chk("arst_out", int'({tx_en, bit_stb, data_bit}), 0);
    tick(1);
    rst = 1'b0;
    stb_cyc.delete(); stb_bit.delete();
    tick(10);
    chk("arst_quiet_stb", stb_cyc.size(), 0);
    chk("arst_quiet_mode", int'(mode), 0);

    // full mode cycle
    for (int i = 0; i < 4; i++) begin
      PB_db = 1'b1;
      tick(1);
      chk($sformatf("cycle_mode%0d", i), int'(mode), exp_modes[i]);
      PB_db = 1'b0;
      tick(6);
    end
    chk("cycle_tx_en_off", int'(tx_en), 0);
    chk("cycle_bit_off", int'(data_bit), 0);

    // button held through reset release is not a press
    rst = 1'b1;
    PB_db = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("held_rst_mode", int'(mode), 0);
    PB_db = 1'b0;
    tick(2);
    PB_db = 1'b1;
    tick(1);
    chk("held_rst_repress", int'(mode), 1);
    PB_db = 1'b0;
    tick(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
